// File: rtl/codec_frame_gen.sv
// rtl/codec_frame_gen.sv - codec power-down sequencing, BICK/LRCK TDM128 frame generation
//
// Runs entirely on clk_256fs. Holds the codec in power-down for PDN_HOLD_CYCLES,
// then releases pdn and starts BICK (clk/2) and a one-BICK-wide LRCK frame sync.
// After STARTUP_CYCLES of running clocks the block enters RUN on the next frame
// boundary and starts issuing per-frame sample strobes and slot/bit positions.
//
// Ports:
//   clk_256fs      in   system audio clock, 256x sample rate
//   rst_n          in   asynchronous active-low reset
//   restart        in   sync pulse, re-runs the full power-down/startup sequence
//   pdn            out  codec power-down, active low
//   bick           out  bit clock, clk_256fs/2
//   lrck           out  frame sync, high for first BICK period of frame
//   ready          out  high while frames are valid
//   sample_strobe  out  1-cycle pulse at start of each valid frame
//   slot[1:0]      out  current TDM slot 0..3
//   bit_index[6:0] out  current BICK index in frame 0..127

module codec_frame_gen #(
  parameter int PDN_HOLD_CYCLES = 4096,
  parameter int STARTUP_CYCLES  = 65536
) (
  input  logic       clk_256fs,
  input  logic       rst_n,
  input  logic       restart,
  output logic       pdn,
  output logic       bick,
  output logic       lrck,
  output logic       ready,
  output logic       sample_strobe,
  output logic [1:0] slot,
  output logic [6:0] bit_index
);

  localparam int HOLD_W  = (PDN_HOLD_CYCLES > 1) ? $clog2(PDN_HOLD_CYCLES) : 1;
  localparam int START_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(PDN_HOLD_CYCLES - 1);
  localparam logic [START_W-1:0] START_LAST = START_W'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PDN  = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_phase;
  logic [7:0]           w_phase_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic [START_W-1:0]   r_start_cnt;
  logic [START_W-1:0]   w_start_nxt;

  logic                 r_pdn, r_bick, r_lrck, r_ready, r_strobe;
  logic [1:0]           r_slot;
  logic [6:0]           r_bit_index;
  logic                 w_pdn_nxt, w_bick_nxt, w_lrck_nxt, w_ready_nxt, w_strobe_nxt;
  logic [1:0]           w_slot_nxt;
  logic [6:0]           w_bit_index_nxt;

  always_ff @(posedge clk_256fs or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PDN;
      r_phase     <= 8'd0;
      r_hold_cnt  <= '0;
      r_start_cnt <= '0;
      r_pdn       <= 1'b0;
      r_bick      <= 1'b0;
      r_lrck      <= 1'b0;
      r_ready     <= 1'b0;
      r_strobe    <= 1'b0;
      r_slot      <= 2'd0;
      r_bit_index <= 7'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_start_cnt <= w_start_nxt;
      r_pdn       <= w_pdn_nxt;
      r_bick      <= w_bick_nxt;
      r_lrck      <= w_lrck_nxt;
      r_ready     <= w_ready_nxt;
      r_strobe    <= w_strobe_nxt;
      r_slot      <= w_slot_nxt;
      r_bit_index <= w_bit_index_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + 8'd1;
    w_hold_nxt  = r_hold_cnt;
    w_start_nxt = r_start_cnt;

    case (r_state)
      S_PDN: begin
        // Phase stays parked at 0 so the first WAIT cycle starts a fresh frame.
        w_phase_nxt = 8'd0;
        w_start_nxt = '0;
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = S_WAIT;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // Saturating startup count; leave only at a frame wrap so RUN
        // always begins with phase 0.
        if (r_start_cnt != START_LAST) begin
          w_start_nxt = r_start_cnt + 1'b1;
        end else if (r_phase == 8'hFF) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_PDN;
        w_phase_nxt = 8'd0;
        w_hold_nxt  = '0;
        w_start_nxt = '0;
      end
    endcase

    // Restart overrides whatever transition the state machine chose.
    if (restart) begin
      w_state_nxt = S_PDN;
      w_phase_nxt = 8'd0;
      w_hold_nxt  = '0;
      w_start_nxt = '0;
    end

    // Outputs are registered images of the post-edge phase/state.
    w_pdn_nxt       = (w_state_nxt != S_PDN);
    w_bick_nxt      = w_phase_nxt[0];
    w_lrck_nxt      = (w_state_nxt != S_PDN) && (w_phase_nxt[7:1] == 7'd0);
    w_ready_nxt     = (w_state_nxt == S_RUN);
    w_strobe_nxt    = (w_state_nxt == S_RUN) && (w_phase_nxt == 8'd0);
    w_slot_nxt      = w_phase_nxt[7:6];
    w_bit_index_nxt = w_phase_nxt[7:1];
  end

  assign pdn           = r_pdn;
  assign bick          = r_bick;
  assign lrck          = r_lrck;
  assign ready         = r_ready;
  assign sample_strobe = r_strobe;
  assign slot          = r_slot;
  assign bit_index     = r_bit_index;

endmodule

// File: tb/tb_codec_frame_gen.sv
// tb/tb_codec_frame_gen.sv - self-checking bench for codec_frame_gen

module tb_codec_frame_gen;

  localparam int PDN_HOLD = 8;
  localparam int STARTUP  = 300;

  logic       clk_256fs;
  logic       rst_n;
  logic       restart;
  logic       pdn, bick, lrck, ready, sample_strobe;
  logic [1:0] slot;
  logic [6:0] bit_index;

  int n_total = 0;
  int n_bad   = 0;

  logic [13:0] sb_q[$];

  int m_st, m_hold, m_start, m_ph;

  codec_frame_gen #(
    .PDN_HOLD_CYCLES(PDN_HOLD),
    .STARTUP_CYCLES (STARTUP)
  ) dut (
    .clk_256fs    (clk_256fs),
    .rst_n        (rst_n),
    .restart      (restart),
    .pdn          (pdn),
    .bick         (bick),
    .lrck         (lrck),
    .ready        (ready),
    .sample_strobe(sample_strobe),
    .slot         (slot),
    .bit_index    (bit_index)
  );

  initial clk_256fs = 1'b0;
  always #5 clk_256fs = ~clk_256fs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] dut_vec();
    return {pdn, bick, lrck, ready, sample_strobe, slot, bit_index};
  endfunction

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_start = 0; m_ph = 0;
  endtask

  // Reference behaviour of one clock edge: 0=power-down, 1=wait, 2=run.
  task automatic model_edge();
    if (!rst_n || restart) begin
      model_reset();
    end else begin
      case (m_st)
        0: if (m_hold == PDN_HOLD - 1) begin m_st = 1; m_ph = 0; m_hold = 0; end
           else m_hold++;
        1: begin
             if (m_start == STARTUP - 1 && m_ph == 255) m_st = 2;
             if (m_start < STARTUP - 1) m_start++;
             m_ph = (m_ph + 1) % 256;
           end
        default: m_ph = (m_ph + 1) % 256;
      endcase
    end
  endtask

  function automatic logic [13:0] model_vec();
    logic       e_pdn, e_bick, e_lrck, e_rdy, e_stb;
    logic [1:0] e_slot;
    logic [6:0] e_bit;
    e_pdn  = (m_st != 0);
    e_bick = (m_ph % 2) == 1;
    e_lrck = (m_st != 0) && (m_ph < 2);
    e_rdy  = (m_st == 2);
    e_stb  = (m_st == 2) && (m_ph == 0);
    e_slot = 2'(m_ph / 64);
    e_bit  = 7'(m_ph / 2);
    return {e_pdn, e_bick, e_lrck, e_rdy, e_stb, e_slot, e_bit};
  endfunction

  task automatic step();
    @(posedge clk_256fs);
    model_edge();
    sb_q.push_back(model_vec());
    @(negedge clk_256fs);
    if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("sb_outputs", 32'(dut_vec()), 32'(sb_q.pop_front()));
  endtask

  task automatic run_to_ready(input string tag);
    int n;
    n = 0;
    while (pdn == 1'b0 && n < 64) begin step(); n++; end
    chk({tag, "_pdn_low_edges"}, 32'(n), 32'(PDN_HOLD));
    chk({tag, "_bick_wait0"}, 32'(bick), 32'd0);
    chk({tag, "_lrck_wait0"}, 32'(lrck), 32'd1);
    n = 0;
    while (ready == 1'b0 && n < 2000) begin step(); n++; end
    chk({tag, "_ready_wait_cycle"}, 32'(n), 32'd512);
    chk({tag, "_first_strobe"}, 32'(sample_strobe), 32'd1);
    chk({tag, "_first_bit_index"}, 32'(bit_index), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    int strobes, lrcks;
    strobes = 0; lrcks = 0;
    for (int p = 1; p <= 256; p++) begin
      step();
      if (p == 128) begin
        chk({tag, "_slot_p128"}, 32'(slot), 32'd2);
        chk({tag, "_bit_p128"}, 32'(bit_index), 32'd64);
      end
      if (p == 255) chk({tag, "_bit_p255"}, 32'(bit_index), 32'd127);
      if (p < 256) begin
        strobes += int'(sample_strobe);
        lrcks   += int'(lrck);
      end else begin
        chk({tag, "_strobe_next_frame"}, 32'(sample_strobe), 32'd1);
      end
    end
    chk({tag, "_strobes_mid_frame"}, 32'(strobes), 32'd0);
    chk({tag, "_lrck_high_p1_only"}, 32'(lrcks), 32'd1);
  endtask

  initial begin
    int rd;
    rst_n   = 1'b0;
    restart = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_outputs", 32'(dut_vec()), 32'd0);

    // Scenarios 1-3: power-up sequence and frame layout.
    rst_n = 1'b1;
    run_to_ready("boot");
    check_frame("boot");

    // Scenario 4: restart mid-RUN at phase 100.
    repeat (100) step();
    chk("phase100_bit", 32'(bit_index), 32'd50);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rst_pdn", 32'(pdn), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_bick", 32'(bick), 32'd0);
    chk("rst_strobe", 32'(sample_strobe), 32'd0);
    run_to_ready("restart");
    check_frame("restart");

    // Scenario 5: restart on the WAIT->RUN edge.
    restart = 1'b1;
    step();
    restart = 1'b0;
    repeat (PDN_HOLD) step();
    chk("s5_pdn_high", 32'(pdn), 32'd1);
    repeat (511) step();
    chk("s5_last_wait_bit", 32'(bit_index), 32'd127);
    chk("s5_not_ready_yet", 32'(ready), 32'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("s5_pdn_low", 32'(pdn), 32'd0);
    chk("s5_ready_low", 32'(ready), 32'd0);
    rd = 0;
    for (int i = 0; i < PDN_HOLD + 511; i++) begin
      step();
      rd += int'(ready);
    end
    chk("s5_ready_never", 32'(rd), 32'd0);
    step();
    chk("s5_ready_after_full_seq", 32'(ready), 32'd1);

    // Scenario 6: asynchronous reset between edges in RUN.
    repeat (37) step();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    run_to_ready("post_async");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
